// File: rtl/img_process_pkg.sv
`default_nettype none
// ============================================================================
// Module      : img_process_pkg
// Description : Shared constants, types and pixel helpers for the img_process
//               streaming edge filter (luminance, window, gradients).
// Revision    : 1.0 - initial release
// ============================================================================
package img_process_pkg;

    localparam int c_img_w_default  = 1280;
    localparam int c_img_h_default  = 720;
    localparam int c_thresh_default = 60;

    localparam int c_wr = 77;
    localparam int c_wg = 150;
    localparam int c_wb = 29;

    localparam int c_pix_w   = 16;
    localparam int c_gray_w  = 8;
    localparam int c_grad_w  = 11;
    localparam int c_latency = 4;

    typedef logic        [c_pix_w-1:0]  pix_t;
    typedef logic        [c_gray_w-1:0] gray_t;
    typedef logic signed [c_grad_w-1:0] grad_t;
    typedef logic        [c_grad_w-1:0] mag_t;

    // 3x3 window, p<row><col>; p22 is the newest (bottom-right) pixel
    typedef struct packed {
        gray_t p00, p01, p02;
        gray_t p10, p11, p12;
        gray_t p20, p21, p22;
    } window_t;

    // Weighted luminance; weights sum to 256 so the 16-bit accumulator never overflows
    function automatic gray_t rgb565_to_gray(input pix_t px);
        logic [7:0]  r8, g8, b8;
        logic [15:0] acc;
        r8  = {px[15:11], px[15:13]};
        g8  = {px[10:5],  px[10:9]};
        b8  = {px[4:0],   px[4:2]};
        acc = 16'(c_wr) * {8'd0, r8} + 16'(c_wg) * {8'd0, g8} + 16'(c_wb) * {8'd0, b8};
        return acc[15:8];
    endfunction

    function automatic pix_t gray_to_rgb565(input gray_t g);
        return {g[7:3], g[7:2], g[7:3]};
    endfunction

    // One Sobel column/row term a + 2b + c (max 1020, fits 11 bits)
    function automatic mag_t tap_sum(input gray_t a, input gray_t b, input gray_t c);
        return mag_t'(a) + {2'b00, b, 1'b0} + mag_t'(c);
    endfunction

    function automatic mag_t abs_grad(input grad_t g);
        return g[c_grad_w-1] ? mag_t'(-g) : mag_t'(g);
    endfunction

endpackage
`default_nettype wire

// File: rtl/img_line_buf.sv
`default_nettype none
// ============================================================================
// Module      : img_line_buf
// Description : Two column-addressed line buffers feeding a 3x3 luminance
//               window, plus the frame position counters and border flag.
// Revision    : 1.0 - initial release
// ============================================================================
module img_line_buf
    import img_process_pkg::*;
#(
    parameter int IMG_W = c_img_w_default,
    parameter int IMG_H = c_img_h_default
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_vld,
    input  gray_t   i_gray,
    input  logic    i_sop,
    input  logic    i_eop,
    output window_t o_win,
    output logic    o_vld,
    output logic    o_sop,
    output logic    o_eop,
    output logic    o_inner
);

    localparam int c_col_w = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int c_row_w = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [c_col_w-1:0] r_col;
    logic [c_row_w-1:0] r_row;
    logic [c_col_w-1:0] w_col;
    logic [c_row_w-1:0] w_row;
    gray_t              r_lb1 [IMG_W];
    gray_t              r_lb2 [IMG_W];
    gray_t              w_tap1;
    gray_t              w_tap2;

    // Position of the incoming pixel (sop restarts at the origin) and its line-buffer taps
    always_comb begin
        w_col  = i_sop ? '0 : r_col;
        w_row  = i_sop ? '0 : r_row;
        w_tap1 = r_lb1[w_col];
        w_tap2 = r_lb2[w_col];
    end

    // Line buffers: read-before-write, lb2 takes what lb1 held one line ago
    always_ff @(posedge clk) begin
        if (i_vld) begin
            r_lb1[w_col] <= i_gray;
            r_lb2[w_col] <= w_tap1;
        end
    end

    // Position counters, window shift and border flag advance only on valid pixels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col   <= '0;
            r_row   <= '0;
            o_win   <= '0;
            o_vld   <= 1'b0;
            o_sop   <= 1'b0;
            o_eop   <= 1'b0;
            o_inner <= 1'b0;
        end else begin
            o_vld <= i_vld;
            o_sop <= i_vld & i_sop;
            o_eop <= i_vld & i_eop;
            if (i_vld) begin
                if (w_col == c_col_w'(IMG_W - 1)) begin
                    r_col <= '0;
                    r_row <= (w_row == c_row_w'(IMG_H - 1)) ? '0 : w_row + 1'b1;
                end else begin
                    r_col <= w_col + 1'b1;
                    r_row <= w_row;
                end
                o_win.p00 <= o_win.p01;
                o_win.p01 <= o_win.p02;
                o_win.p02 <= w_tap2;
                o_win.p10 <= o_win.p11;
                o_win.p11 <= o_win.p12;
                o_win.p12 <= w_tap1;
                o_win.p20 <= o_win.p21;
                o_win.p21 <= o_win.p22;
                o_win.p22 <= i_gray;
                o_inner   <= (w_row >= c_row_w'(2)) && (w_col >= c_col_w'(2));
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/img_process.sv
`default_nettype none
// ============================================================================
// Module      : img_process
// Description : RGB565 -> luminance -> 3x3 Sobel -> binarized RGB565 stream
//               filter, 4-cycle fixed latency, sop/eop preserved.
//               IMP_SOBEL_EN defined  : edge output (white = edge).
//               IMP_SOBEL_EN undefined: gray re-packed as RGB565.
// Revision    : 1.0 - initial release
// ============================================================================
module img_process
    import img_process_pkg::*;
#(
    parameter int IMG_W  = c_img_w_default,
    parameter int IMG_H  = c_img_h_default,
    parameter int THRESH = c_thresh_default
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] din,
    input  logic        din_vld,
    input  logic        din_sop,
    input  logic        din_eop,
    output logic [15:0] dout,
    output logic        dout_vld,
    output logic        dout_sop,
    output logic        dout_eop
);

    pix_t  r_s0_pix;
    logic  r_s0_vld, r_s0_sop, r_s0_eop;
    gray_t r_s1_gray;
    logic  r_s1_vld, r_s1_sop, r_s1_eop;

    // Capture the input pixel and its qualified framing flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0_pix <= '0;
            r_s0_vld <= 1'b0;
            r_s0_sop <= 1'b0;
            r_s0_eop <= 1'b0;
        end else begin
            r_s0_vld <= din_vld;
            r_s0_sop <= din_vld & din_sop;
            r_s0_eop <= din_vld & din_eop;
            if (din_vld) r_s0_pix <= din;
        end
    end

    // Luminance conversion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_gray <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_sop  <= 1'b0;
            r_s1_eop  <= 1'b0;
        end else begin
            r_s1_vld <= r_s0_vld;
            r_s1_sop <= r_s0_sop;
            r_s1_eop <= r_s0_eop;
            if (r_s0_vld) r_s1_gray <= rgb565_to_gray(r_s0_pix);
        end
    end

`ifdef IMP_SOBEL_EN
    window_t w_win;
    logic    w_win_vld, w_win_sop, w_win_eop, w_win_inner;
    grad_t   r_gx, r_gy;
    logic    r_s3_vld, r_s3_sop, r_s3_eop, r_s3_inner;
    mag_t    w_mag;

    img_line_buf #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_line_buf (
        .clk     (clk),
        .rst     (rst),
        .i_vld   (r_s1_vld),
        .i_gray  (r_s1_gray),
        .i_sop   (r_s1_sop),
        .i_eop   (r_s1_eop),
        .o_win   (w_win),
        .o_vld   (w_win_vld),
        .o_sop   (w_win_sop),
        .o_eop   (w_win_eop),
        .o_inner (w_win_inner)
    );

    // Sobel gradients: right minus left column, bottom minus top row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gx       <= '0;
            r_gy       <= '0;
            r_s3_vld   <= 1'b0;
            r_s3_sop   <= 1'b0;
            r_s3_eop   <= 1'b0;
            r_s3_inner <= 1'b0;
        end else begin
            r_s3_vld <= w_win_vld;
            r_s3_sop <= w_win_sop;
            r_s3_eop <= w_win_eop;
            if (w_win_vld) begin
                r_gx <= grad_t'(tap_sum(w_win.p02, w_win.p12, w_win.p22)
                              - tap_sum(w_win.p00, w_win.p10, w_win.p20));
                r_gy <= grad_t'(tap_sum(w_win.p20, w_win.p21, w_win.p22)
                              - tap_sum(w_win.p00, w_win.p01, w_win.p02));
                r_s3_inner <= w_win_inner;
            end
        end
    end

    // Gradient magnitude approximation |Gx|+|Gy|, at most 2040
    always_comb begin
        w_mag = abs_grad(r_gx) + abs_grad(r_gy);
    end

    // Threshold and border mask into the binarized output pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout     <= '0;
            dout_vld <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
        end else begin
            dout_vld <= r_s3_vld;
            dout_sop <= r_s3_sop;
            dout_eop <= r_s3_eop;
            if (r_s3_vld) dout <= (r_s3_inner && (w_mag >= mag_t'(THRESH))) ? 16'hFFFF : 16'h0000;
        end
    end
`else
    gray_t r_s2_gray, r_s3_gray;
    logic  r_s2_vld, r_s2_sop, r_s2_eop;
    logic  r_s3_vld, r_s3_sop, r_s3_eop;

    // Delay line standing in for the window and gradient stages so latency stays 4
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_gray <= '0;
            r_s3_gray <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_sop  <= 1'b0;
            r_s2_eop  <= 1'b0;
            r_s3_vld  <= 1'b0;
            r_s3_sop  <= 1'b0;
            r_s3_eop  <= 1'b0;
        end else begin
            r_s2_vld <= r_s1_vld;
            r_s2_sop <= r_s1_sop;
            r_s2_eop <= r_s1_eop;
            r_s3_vld <= r_s2_vld;
            r_s3_sop <= r_s2_sop;
            r_s3_eop <= r_s2_eop;
            if (r_s1_vld) r_s2_gray <= r_s1_gray;
            if (r_s2_vld) r_s3_gray <= r_s2_gray;
        end
    end

    // Re-pack luminance as a gray RGB565 pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout     <= '0;
            dout_vld <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
        end else begin
            dout_vld <= r_s3_vld;
            dout_sop <= r_s3_sop;
            dout_eop <= r_s3_eop;
            if (r_s3_vld) dout <= gray_to_rgb565(r_s3_gray);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_img_process.sv
`default_nettype none
// ============================================================================
// Module      : tb_img_process
// Description : Self-checking bench for img_process on an 8x4 frame, with a
//               frame-level reference model (luminance + Sobel or gray).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_img_process;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int TH = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] din = '0;
    logic        din_vld = 1'b0;
    logic        din_sop = 1'b0;
    logic        din_eop = 1'b0;
    logic [15:0] dout;
    logic        dout_vld;
    logic        dout_sop;
    logic        dout_eop;

    img_process #(
        .IMG_W  (W),
        .IMG_H  (H),
        .THRESH (TH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_vld  (din_vld),
        .din_sop  (din_sop),
        .din_eop  (din_eop),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_sop (dout_sop),
        .dout_eop (dout_eop)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] pix;
        logic        sop;
        logic        eop;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   mrow  = 0;
    int   mcol  = 0;
    int   gimg [H][W];

    // Luminance straight from the channel-expansion and weighting rules
    function automatic int luma(input logic [15:0] p);
        int r, g, b;
        r = int'(p[15:11]); r = r * 8 + r / 4;
        g = int'(p[10:5]);  g = g * 4 + g / 16;
        b = int'(p[4:0]);   b = b * 8 + b / 4;
        return (77 * r + 150 * g + 29 * b) / 256;
    endfunction

    // Expected output for the pixel at (row, col), using the frame image so far
    function automatic logic [15:0] model_out(input int row, input int col);
`ifdef IMP_SOBEL_EN
        int gx, gy, v, mag;
        if (row < 2 || col < 2) return 16'h0000;
        gx = 0; gy = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                v  = gimg[row - 2 + i][col - 2 + j];
                gx += v * (j - 1) * ((i == 1) ? 2 : 1);
                gy += v * (i - 1) * ((j == 1) ? 2 : 1);
            end
        end
        mag = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
        return (mag >= TH) ? 16'hFFFF : 16'h0000;
`else
        logic [7:0] gv;
        gv = 8'(gimg[row][col]);
        return {gv[7:3], gv[7:2], gv[7:3]};
`endif
    endfunction

    // Drive one cycle of input; valid pixels are entered into the model and the expect queue
    task automatic drive(input logic v, input logic [15:0] d, input logic s, input logic e);
        din_vld = v; din = d; din_sop = s; din_eop = e;
        @(posedge clk);
        cyc++;
        if (v) begin
            if (s) begin mrow = 0; mcol = 0; end
            gimg[mrow][mcol] = luma(d);
            q.push_back('{cyc, model_out(mrow, mcol), s, e});
            if (mcol == W - 1) begin
                mcol = 0;
                mrow = (mrow == H - 1) ? 0 : mrow + 1;
            end else begin
                mcol++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            din_vld = i[0]; din = 16'($urandom); din_sop = 1'b1; din_eop = i[1];
            @(posedge clk); #1;
            total++;
            if ({dout, dout_vld, dout_sop, dout_eop} !== 19'd0) begin
                bad++;
                $display("FAIL reset_hold dout=%h vld=%b sop=%b eop=%b required all zero", dout, dout_vld, dout_sop, dout_eop);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) drive(1'b1, 16'($urandom), i == 0, 1'b0);
        total++;
        if (dout_vld !== 1'b1) begin
            bad++;
            $display("FAIL reset_prefill vld=%b required 1", dout_vld);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({dout, dout_vld, dout_sop, dout_eop} !== 19'd0) begin
            bad++;
            $display("FAIL reset_async dout=%h vld=%b required all zero", dout, dout_vld);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        mrow = 0; mcol = 0;
    endtask

    // Stream nfrm frames (optionally preceded by an aborted partial frame of pre pixels).
    // kind: 0 flat white, 1 vertical edge, 2 luminance probe, 3 random. gap: 0 none, 1 alternate, 2 random
    task automatic test_stream(input string name, input int kind, input int nfrm, input int gap, input int pre);
        int          n, nout, hits, p, col, budget, want_hits;
        logic        v;
        logic [15:0] pix;
        exp_t        e;
        int          N;
        N = pre + nfrm * W * H;
        n = 0; nout = 0; hits = 0;
        budget = 4 * N + 50;
        for (int t = 0; t < budget && (n < N || q.size() > 0); t++) begin
            case (gap)
                1:       v = (t % 2 == 0);
                2:       v = ($urandom_range(0, 3) != 0);
                default: v = 1'b1;
            endcase
            v   = v && (n < N);
            p   = (n < pre) ? n : (n - pre) % (W * H);
            col = p % W;
            case (kind)
                0:       pix = 16'hFFFF;
                1:       pix = (col < 4) ? 16'h0000 : 16'hFFFF;
                2:       pix = (p == 0) ? 16'hF800 : (p == 1) ? 16'hFFFF : 16'($urandom);
                default: pix = 16'($urandom);
            endcase
            drive(v, pix, v && (p == 0), v && (n >= pre) && (p == W * H - 1));
            if (v) n++;
            total++;
            if (q.size() > 0 && q[0].cyc + 4 == cyc) begin
                e = q.pop_front();
                if ({dout_vld, dout, dout_sop, dout_eop} !== {1'b1, e.pix, e.sop, e.eop}) begin
                    bad++;
                    $display("FAIL %s cyc=%0d dout=%h vld=%b sop=%b eop=%b required dout=%h vld=1 sop=%b eop=%b",
                             name, cyc, dout, dout_vld, dout_sop, dout_eop, e.pix, e.sop, e.eop);
                end
                if (kind == 2 && nout < 2) begin
                    total++;
`ifdef IMP_SOBEL_EN
                    if (dout !== 16'h0000) begin
`else
                    if (dout !== ((nout == 0) ? 16'h4A69 : 16'hFFFF)) begin
`endif
                        bad++;
                        $display("FAIL %s_probe%0d dout=%h", name, nout, dout);
                    end
                end
                if (dout === 16'hFFFF) hits++;
                nout++;
            end else if (dout_vld !== 1'b0) begin
                bad++;
                $display("FAIL %s_idle cyc=%0d vld=%b required 0", name, cyc, dout_vld);
            end
        end
        total++;
        if (q.size() != 0 || nout != N) begin
            bad++;
            $display("FAIL %s_count outputs=%0d required %0d (pending %0d)", name, nout, N, q.size());
            q.delete();
        end
        if (kind == 0 || kind == 1) begin
`ifdef IMP_SOBEL_EN
            want_hits = (kind == 0) ? 0 : 4 * nfrm;
`else
            want_hits = (kind == 0) ? W * H * nfrm : 16 * nfrm;
`endif
            total++;
            if (hits != want_hits) begin
                bad++;
                $display("FAIL %s_white white_outputs=%0d required %0d", name, hits, want_hits);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream("luma",    2, 1, 0, 0);
        test_stream("flat",    0, 1, 0, 0);
        test_stream("vedge",   1, 1, 0, 0);
        test_stream("gapped",  1, 1, 1, 0);
        test_stream("framing", 3, 3, 2, 0);
        test_stream("restart", 3, 1, 0, 13);
        test_stream("b2b",     1, 2, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/img_process.md
Name: img_process

Overview:
- Streaming video filter between the camera capture path (OV5640, RGB565) and the SDRAM frame-buffer writer.
- Converts each RGB565 pixel to 8-bit luminance, runs a 3x3 Sobel edge detector over the luminance, and emits a binarized RGB565 pixel (white = edge, black = non-edge).
- Emits exactly one output pixel per input pixel, with fixed latency and sop/eop framing preserved.

Parameters:
- IMG_W, 1280, active pixels per line.
- IMG_H, 720, active lines per frame.
- THRESH, 60, edge threshold compared against |Gx|+|Gy|.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  16  input pixel, RGB565 {R[15:11],G[10:5],B[4:0]}.
- din_vld  in  1  din valid this cycle.
- din_sop  in  1  first pixel of frame; qualified by din_vld.
- din_eop  in  1  last pixel of frame; qualified by din_vld.
- dout  out  16  output pixel, RGB565.
- dout_vld  out  1  dout valid.
- dout_sop  out  1  frame start, aligned with dout_vld.
- dout_eop  out  1  frame end, aligned with dout_vld.

Behaviour:
- Reset: dout=0, dout_vld=0, dout_sop=0, dout_eop=0; column/row counters and all pipeline valid bits cleared.
  - Reset mid-frame takes effect immediately. Line-buffer RAM contents are not cleared; stale data is masked by the border rule.
- Latency: a pixel sampled with din_vld=1 at edge k appears with dout_vld=1 after edge k+4. No backpressure.
  - Valid gaps are allowed. Pipeline stages advance every cycle with per-stage valid bits, and the window/counters update only on valid pixels, so the latency stays exactly 4.
- Stage 1, luminance:
  - Expand channels: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
  - gray = (77*R8 + 150*G8 + 29*B8) >> 8, computed with a 16-bit accumulator; result is 8 bits.
- Stage 2, counters and window:
  - col/row counters advance on each valid pixel. col wraps IMG_W-1 -> 0 and increments row; row wraps IMG_H-1 -> 0.
  - A valid pixel with sop forces the pixel position to (row 0, col 0). A mid-frame sop restarts the frame.
  - Two IMG_W x 8 line buffers, addressed by col, read-before-write: tap1=lb1[col], tap2=lb2[col]; then lb1[col]<=gray, lb2[col]<=tap1.
  - The 3x3 window shifts by one column per valid pixel. The current pixel is the bottom-right element.
- Stage 3, gradients (signed 11-bit):
  - Gx = (p02+2p12+p22) - (p00+2p10+p20)
  - Gy = (p20+2p21+p22) - (p00+2p01+p02)
- Stage 4, output:
  - mag = |Gx|+|Gy| (11 bits, max 2040).
  - dout = 16'hFFFF if mag >= THRESH, else 16'h0000.
- Border rule: if the window's bottom-right pixel has row<2 or col<2, dout = 16'h0000.
- dout_sop and dout_eop are din_sop and din_eop delayed through the same valid pipeline.

Optional Feature:
- Macro: IMP_SOBEL_EN.
- Defined: Sobel edge output as described above.
- Undefined: dout = gray re-packed as RGB565 {gray[7:3],gray[7:2],gray[7:3]}. Line buffers and Sobel logic are not built. Latency remains 4 cycles via delay registers. Flags are unchanged.

Decomposition:
- Package img_process_pkg holds:
  - Default IMG_W, IMG_H and THRESH.
  - Luminance weights 77/150/29.
  - Pixel width 16, gray width 8, gradient width 11.
  - Pipeline latency constant 4.
- Sub-module img_line_buf: the two line buffers, column-indexed taps and 3x3 window registers. Output is the window plus its valid bit.

Test Plan:
- Reset: hold rst=1 with din_vld toggling -> dout=0, dout_vld/sop/eop=0 throughout; deassert -> the next frame processes normally.
- Luminance, macro undefined: din=16'hF800 -> gray=76, dout=16'h4A69. din=16'hFFFF -> dout=16'hFFFF, 4 cycles after input.
- Flat frame, IMG_W=8, IMG_H=4, IMP_SOBEL_EN, all pixels 16'hFFFF -> all 32 outputs 16'h0000.
- Vertical edge, same size: cols 0-3 = 16'h0000, cols 4-7 = 16'hFFFF -> rows 2-3, cols 4 and 5 give 16'hFFFF (Gx=1020); all other outputs 0.
- Framing, 1280x720 random pixels -> dout_sop exactly 4 cycles after din_sop, dout_eop exactly 4 cycles after din_eop, dout_vld count = 921600.
- Gapped valid: repeat the edge test with din_vld alternating 1/0 -> identical output values, each exactly 4 cycles after its input.
